// File: rtl/bidir_switch_arb_pkg.sv
// Shared types and constants for the bidirectional pass-switch arbiter.
package bidir_sw_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TURN    = 2'd1,
        GRANT_A = 2'd2,
        GRANT_B = 2'd3
    } state_t;

    // Owner encoding is chosen so that it can be copied straight onto dir.
    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    localparam logic DIR_A2B = 1'b0;
    localparam logic DIR_B2A = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bidir_switch_arb_if.sv
// Request/grant and switch-control bundle between the requesters and the arbiter.
interface bidir_switch_arb_if;

    logic req_a;
    logic req_b;
    logic gnt_a;
    logic gnt_b;
    logic sw_en;
    logic dir;
    logic turn;

    modport master (
        output req_a,
        output req_b,
        input  gnt_a,
        input  gnt_b,
        input  sw_en,
        input  dir,
        input  turn
    );

    modport slave (
        input  req_a,
        input  req_b,
        output gnt_a,
        output gnt_b,
        output sw_en,
        output dir,
        output turn
    );

endinterface

// File: rtl/bidir_switch_arb_rr2.sv
// Two-requester round-robin picker: a lone requester wins, a tie goes to the
// side that did not own the net last.
module bidir_rr2
    import bidir_sw_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  owner_t last_owner,
    output logic   valid,
    output owner_t winner
);

    always_comb begin
        valid  = req_a | req_b;
        winner = OWN_A;
        if (req_a && req_b) begin
            winner = (last_owner == OWN_A) ? OWN_B : OWN_A;
        end else if (req_b) begin
            winner = OWN_B;
        end
    end

endmodule

// File: rtl/bidir_switch_arb.sv
// Break-before-make arbiter for a shared bidirectional net: owns the pass-switch
// enable and direction, and inserts a turnaround gap around every ownership change.
module bidir_switch_arb
    import bidir_sw_pkg::*;
#(
    parameter int TURN_CYC = 2,
    parameter int MAX_HOLD = 16
) (
    input logic               clk,
    input logic               rst_n,
    bidir_switch_arb_if.slave bus
);

    localparam int              CNT_MAX   = max_int(TURN_CYC, MAX_HOLD);
    localparam int              CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_t            target_q, target_d;
    owner_t            last_q, last_d;
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;
    logic              sw_en_q, sw_en_d;
    logic              dir_q, dir_d;
    logic              turn_q, turn_d;

    logic              pick_valid;
    owner_t            pick_winner;
    logic              target_req;
    logic              own_req;
    logic              other_req;
    owner_t            other_side;
    logic [CNT_W-1:0]  hold_next;
    logic              hold_hit;

    bidir_rr2 u_rr (
        .req_a      (bus.req_a),
        .req_b      (bus.req_b),
        .last_owner (last_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign target_req = (target_q == OWN_A) ? bus.req_a : bus.req_b;
    assign own_req    = (state_q == GRANT_A) ? bus.req_a : bus.req_b;
    assign other_req  = (state_q == GRANT_A) ? bus.req_b : bus.req_a;
    assign other_side = (state_q == GRANT_A) ? OWN_B : OWN_A;

    // The shared counter doubles as the hold timer in GRANT; it saturates so a
    // long uncontested grant is preempted on the first cycle the other side asks.
    assign hold_next = (cnt_q >= HOLD_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign hold_hit  = (MAX_HOLD != 0) && (hold_next == HOLD_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        last_d   = last_q;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        sw_en_d  = 1'b0;
        turn_d   = 1'b0;
        dir_d    = dir_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = TURN;
                    target_d = pick_winner;
                    dir_d    = pick_winner;
                    turn_d   = 1'b1;
                    cnt_d    = TURN_LOAD;
                end
            end

            TURN: begin
                if (cnt_q != '0) begin
                    turn_d = 1'b1;
                    cnt_d  = cnt_q - CNT_W'(1);
                end else if (target_req) begin
                    state_d = (target_q == OWN_A) ? GRANT_A : GRANT_B;
                    last_d  = target_q;
                    cnt_d   = '0;
                    sw_en_d = 1'b1;
                    gnt_a_d = (target_q == OWN_A);
                    gnt_b_d = (target_q == OWN_B);
                end else begin
                    state_d = IDLE;
                end
            end

            GRANT_A, GRANT_B: begin
                cnt_d = hold_next;
                if (!own_req || (other_req && hold_hit)) begin
                    if (other_req) begin
                        state_d  = TURN;
                        target_d = other_side;
                        dir_d    = other_side;
                        turn_d   = 1'b1;
                        cnt_d    = TURN_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    sw_en_d = 1'b1;
                    gnt_a_d = (state_q == GRANT_A);
                    gnt_b_d = (state_q == GRANT_B);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= OWN_A;
            last_q   <= OWN_B;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            sw_en_q  <= 1'b0;
            dir_q    <= DIR_A2B;
            turn_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            last_q   <= last_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            sw_en_q  <= sw_en_d;
            dir_q    <= dir_d;
            turn_q   <= turn_d;
        end
    end

    assign bus.gnt_a = gnt_a_q;
    assign bus.gnt_b = gnt_b_q;
    assign bus.sw_en = sw_en_q;
    assign bus.dir   = dir_q;
    assign bus.turn  = turn_q;

endmodule

// File: tb/tb_bidir_switch_arb.sv
// Scoreboard bench for bidir_switch_arb: directed vectors queue expected outputs,
// a negedge monitor retires them, and an invariant watcher runs throughout.
module tb_bidir_switch_arb;

    localparam int TURN_CYC = 2;

    // Output vectors are {gnt_a, gnt_b, sw_en, dir, turn}.
    localparam logic [4:0] V_IDLE_0 = 5'b00000;
    localparam logic [4:0] V_IDLE_1 = 5'b00010;
    localparam logic [4:0] V_TURN_A = 5'b00001;
    localparam logic [4:0] V_TURN_B = 5'b00011;
    localparam logic [4:0] V_GNT_A  = 5'b10100;
    localparam logic [4:0] V_GNT_B  = 5'b01110;

    typedef struct {
        int         due;
        int         which;
        logic [4:0] exp;
        string      name;
    } sb_item_t;

    logic       clk;
    logic       rst_n;
    int         cyc;
    int         checks;
    int         failures;
    sb_item_t   sb_q[$];
    logic [4:0] vec_main;
    logic [4:0] vec_nh;
    logic       rst_seen;
    logic       prev_sw;
    logic       prev_dir;
    logic       prev_turn;
    int         off_cnt;
    logic       inv_en;
    logic       ra_r;
    logic       rb_r;
    logic       rstn_r;

    bidir_switch_arb_if bus ();
    bidir_switch_arb_if bus_nh ();

    bidir_switch_arb #(.TURN_CYC(TURN_CYC), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bidir_switch_arb #(.TURN_CYC(TURN_CYC), .MAX_HOLD(0)) dut_nh (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nh)
    );

    assign vec_main = {bus.gnt_a, bus.gnt_b, bus.sw_en, bus.dir, bus.turn};
    assign vec_nh   = {bus_nh.gnt_a, bus_nh.gnt_b, bus_nh.sw_en, bus_nh.dir, bus_nh.turn};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_n;
    end

    task automatic checkOutput(input string name, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got=%b expected=%b", name, cyc, got, exp);
        end
    endtask

    // which: 0 = check MAX_HOLD=4 instance, 1 = check MAX_HOLD=0 instance, 2 = no check.
    task automatic applyStimulus(input int which, input logic rstn, input logic ra, input logic rb,
                                 input logic [4:0] exp, input string name);
        @(posedge clk);
        #1;
        rst_n        = rstn;
        bus.req_a    = ra;
        bus.req_b    = rb;
        bus_nh.req_a = ra;
        bus_nh.req_b = rb;
        if (which != 2) begin
            sb_q.push_back('{due: cyc + 1, which: which, exp: exp, name: name});
        end
    endtask

    always @(negedge clk) begin
        sb_item_t item;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            item = sb_q.pop_front();
            checkOutput(item.name, (item.which == 0) ? vec_main : vec_nh, item.exp);
        end
    end

    // Protocol invariants on the preempting instance, every cycle once out of reset.
    always @(negedge clk) begin
        if (inv_en) begin
            checkOutput("inv_onehot", {4'b0, bus.gnt_a & bus.gnt_b}, 5'b0);
            checkOutput("inv_sw_only_granted", {4'b0, bus.sw_en ^ (bus.gnt_a | bus.gnt_b)}, 5'b0);
            checkOutput("inv_turn_sw_excl", {4'b0, bus.turn & bus.sw_en}, 5'b0);
            checkOutput("inv_dir_stable_sw", {4'b0, prev_sw & bus.sw_en & (bus.dir ^ prev_dir)}, 5'b0);
            checkOutput("inv_dir_only_entering_turn",
                        {4'b0, rst_seen & (bus.dir ^ prev_dir) & ~(bus.turn & ~prev_turn)}, 5'b0);
            checkOutput("inv_break_before_make",
                        {4'b0, bus.sw_en & ~prev_sw & (off_cnt < TURN_CYC)}, 5'b0);
            off_cnt   = bus.sw_en ? 0 : off_cnt + 1;
            prev_sw   = bus.sw_en;
            prev_dir  = bus.dir;
            prev_turn = bus.turn;
        end
    end

    initial begin
        checks       = 0;
        failures     = 0;
        inv_en       = 1'b0;
        prev_sw      = 1'b0;
        prev_dir     = 1'b0;
        prev_turn    = 1'b0;
        off_cnt      = 0;
        rst_n        = 1'b0;
        bus.req_a    = 1'b1;
        bus.req_b    = 1'b0;
        bus_nh.req_a = 1'b1;
        bus_nh.req_b = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 1'b1, 1'b0, V_IDLE_0, "reset_hold");
        inv_en = 1'b1;

        applyStimulus(0, 1'b1, 1'b1, 1'b0, V_TURN_A, "a_turn_1");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, V_TURN_A, "a_turn_2");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, V_GNT_A,  "a_grant");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, V_GNT_A,  "a_hold_alone");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, V_IDLE_0, "a_release_idle");

        applyStimulus(0, 1'b0, 1'b0, 1'b0, V_IDLE_0, "reset_2");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, V_TURN_A, "both_turn_a_1");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, V_TURN_A, "both_turn_a_2");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, V_GNT_A,  "both_grant_a");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, V_TURN_B, "handoff_turn_b_1");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, V_TURN_B, "handoff_turn_b_2");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, V_GNT_B,  "handoff_grant_b");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, V_IDLE_1, "b_release_idle");

        applyStimulus(0, 1'b1, 1'b1, 1'b0, V_TURN_A, "pre_turn_a_1");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, V_TURN_A, "pre_turn_a_2");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, V_GNT_A,  "pre_grant_a_1");
        for (int i = 2; i <= 4; i++) applyStimulus(0, 1'b1, 1'b1, 1'b1, V_GNT_A, $sformatf("pre_grant_a_%0d", i));
        applyStimulus(0, 1'b1, 1'b1, 1'b1, V_TURN_B, "preempt_a_turn_1");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, V_TURN_B, "preempt_a_turn_2");
        for (int i = 1; i <= 4; i++) applyStimulus(0, 1'b1, 1'b1, 1'b1, V_GNT_B, $sformatf("pre_grant_b_%0d", i));
        applyStimulus(0, 1'b1, 1'b1, 1'b1, V_TURN_A, "preempt_b_turn_1");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, V_TURN_A, "preempt_b_turn_2");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, V_GNT_A,  "regrant_a");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, V_IDLE_0, "pre_release_idle");

        applyStimulus(1, 1'b0, 1'b0, 1'b0, V_IDLE_0, "nohold_reset");
        applyStimulus(1, 1'b1, 1'b1, 1'b0, V_TURN_A, "nohold_turn_1");
        applyStimulus(1, 1'b1, 1'b1, 1'b1, V_TURN_A, "nohold_turn_2");
        applyStimulus(1, 1'b1, 1'b1, 1'b1, V_GNT_A,  "nohold_grant");
        for (int i = 0; i < 100; i++) applyStimulus(1, 1'b1, 1'b1, 1'b1, V_GNT_A, "nohold_keep_a");
        applyStimulus(1, 1'b1, 1'b0, 1'b1, V_TURN_B, "nohold_release_turn_b");

        applyStimulus(0, 1'b0, 1'b0, 1'b0, V_IDLE_0, "pulse_reset");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, V_TURN_B, "pulse_turn_b_1");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, V_TURN_B, "pulse_turn_b_2");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, V_IDLE_1, "pulse_back_idle");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, V_IDLE_1, "pulse_stay_idle");

        applyStimulus(0, 1'b1, 1'b0, 1'b1, V_TURN_B, "midrst_turn_b_1");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, V_TURN_B, "midrst_turn_b_2");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, V_GNT_B,  "midrst_grant_b");
        applyStimulus(0, 1'b0, 1'b0, 1'b1, V_IDLE_0, "midrst_reset_opens");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, V_TURN_A, "midrst_rr_turn_a_1");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, V_TURN_A, "midrst_rr_turn_a_2");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, V_GNT_A,  "midrst_rr_grant_a");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, V_IDLE_0, "midrst_release");

        ra_r = 1'b0;
        rb_r = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 5) == 0) ra_r = ~ra_r;
            if ($urandom_range(0, 5) == 0) rb_r = ~rb_r;
            rstn_r = ($urandom_range(0, 499) != 0);
            applyStimulus(2, rstn_r, ra_r, rb_r, V_IDLE_0, "random");
        end
        for (int i = 0; i < 3; i++) applyStimulus(2, 1'b1, 1'b0, 1'b0, V_IDLE_0, "drain");

        checkOutput("scoreboard_drained", (sb_q.size() == 0) ? 5'b0 : 5'b1, 5'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
